instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Fetch/execute sequencer that drives the instruction pointer: issues fetches at the current IP,
//   hands the fetched word to the execute stage, then strobes ip_update/ip_adj to advance or branch.
//   Keeps a mirror of the IP (fetch_addr), handles halt requests and detects fetch timeouts.
// PARAMETERS
//   WORD_SIZE      16   width of IP, instruction word and adjustment
//   INSTR_STEP     1    ip_adj for sequential (non-branch) advance
//   FETCH_TIMEOUT  15   cycles without fetch_ack before FAULT; 0 disables timeout
// PORTS
//   clk            in   1          single clock, rising edge
//   reset_n        in   1          asynchronous, active-low reset
//   run            in   1          level: sequencer may start/continue fetching
//   halt_req       in   1          level/pulse: stop after current instruction
//   fetch_req      out  1          fetch request, held until fetch_ack
//   fetch_addr     out  WORD_SIZE  address to fetch (= IP mirror)
//   fetch_ack      in   1          fetch_data valid this cycle
//   fetch_data     in   WORD_SIZE  fetched instruction word
//   instr          out  WORD_SIZE  latched instruction
//   instr_valid    out  1          one-cycle pulse on EXEC entry
//   exec_done      in   1          execute stage finished current instr
//   branch_taken   in   1          sampled with exec_done
//   branch_offset  in   WORD_SIZE  signed offset, sampled with exec_done
//   ip_adj         out  WORD_SIZE  adjustment applied at ip_update
//   ip_update      out  1          one-cycle IP advance strobe
//   ip_reset       out  1          one-cycle IP clear strobe
//   halted         out  1          sticky, in HALT
//   fault          out  1          sticky, in FAULT
//   state          out  3          current state encoding
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=IDLE, all outputs 0, mirror=0, wait counter=0, halt_pend=0.
//     First cycle after release: ip_reset=1 for exactly one cycle, no fetch that cycle.
//   - States: IDLE=0, FETCH=1, EXEC=2, ADVANCE=3, HALT=4, FAULT=5. All outputs registered.
//   - IDLE: halt_req -> HALT (priority); else run -> FETCH (fetch_req=1 next cycle).
//   - FETCH: fetch_req=1, fetch_addr=mirror. On fetch_ack: instr<=fetch_data, fetch_req<=0,
//     -> EXEC. Counter +1 per cycle without ack; reaching FETCH_TIMEOUT -> FAULT, fetch_req<=0.
//     Ack in the same cycle the counter hits the limit: ack wins.
//   - EXEC: instr_valid=1 first cycle only. On exec_done: ip_adj<=branch_taken?branch_offset:
//     INSTR_STEP -> ADVANCE. exec_done while instr_valid=1 is legal.
//   - ADVANCE: ip_update=1 one cycle; mirror<=mirror+ip_adj modulo 2^WORD_SIZE (wrap, no flag).
//     Next: halt_pend|halt_req -> HALT; else run -> FETCH; else IDLE. halt_pend cleared.
//   - halt_req in FETCH/EXEC sets halt_pend; current instruction completes, IP advances, then HALT.
//   - run dropping mid-instruction: instruction completes; IDLE after ADVANCE.
//   - HALT (halted=1) and FAULT (fault=1): sticky until reset_n; ignore all inputs.
//   - Min instruction: 3 cycles (ack and exec_done each on first cycle). ip_adj holds value
//     until next exec_done; ip_update and ip_reset never assert together.
// CONFIGURATION
//   SINGLE_STEP_EN defined: adds input port step (1 bit). In IDLE with run=0, a step pulse
//     -> FETCH; that instruction completes and ADVANCE returns to IDLE (unless run=1). halt_req
//     priority unchanged. step ignored outside IDLE.
//   SINGLE_STEP_EN undefined: no step port; IDLE leaves only on run or halt_req.
// TESTING
//   1. Reset release, run=1, ack+exec_done immediate, no branch -> ip_reset 1 cycle, then
//      fetch_addr 0,1,2,3 on successive fetches, ip_update every 3rd cycle, ip_adj=1.
//   2. exec_done with branch_taken=1, offset=16'hFFFE at IP=5 -> ip_adj=FFFE, next fetch_addr=3;
//      at IP=FFFF sequential step -> fetch_addr wraps to 0.
//   3. halt_req pulse during EXEC at IP=2 -> ip_update still fires, fetch_addr=3, halted=1,
//      no further fetch_req; run toggling has no effect until reset_n.
//   4. fetch_ack withheld, FETCH_TIMEOUT=15 -> FAULT after 15 cycles, fault=1, fetch_req=0;
//      ack on exactly the 15th cycle -> EXEC, no fault.
//   5. reset_n low mid-EXEC -> all outputs 0 immediately (async), ip_reset pulse after release.
//   6. SINGLE_STEP_EN, run=0: three step pulses -> exactly three ip_update strobes, IDLE between.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer that owns the instruction-pointer mirror and strobes IP updates.
// Optional single-step input is enabled by defining SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int WORD_SIZE     = 16,
  parameter int INSTR_STEP    = 1,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 halt_req,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 fetch_req,
  output logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 fetch_ack,
  input  logic [WORD_SIZE-1:0] fetch_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_offset,
  output logic [WORD_SIZE-1:0] ip_adj,
  output logic                 ip_update,
  output logic                 ip_reset,
  output logic                 halted,
  output logic                 fault,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StExec    = 3'd2,
    StAdvance = 3'd3,
    StHalt    = 3'd4,
    StFault   = 3'd5
  } state_e;

  localparam int CntW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
  localparam logic [WORD_SIZE-1:0] SeqStep = WORD_SIZE'(INSTR_STEP);

  state_e                state_q, state_d;
  logic                  started_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [WORD_SIZE-1:0]  mirror_q, mirror_d;
  logic [WORD_SIZE-1:0]  instr_q, instr_d;
  logic [WORD_SIZE-1:0]  ip_adj_q, ip_adj_d;
  logic                  fetch_req_q, fetch_req_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  ip_update_q, ip_update_d;
  logic                  ip_reset_q, ip_reset_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic                  go;
  logic                  timeout_hit;

`ifdef SINGLE_STEP_EN
  assign go = run | step;
`else
  assign go = run;
`endif

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The first cycle after reset release is reserved for the ip_reset strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (started_q) begin
          if (halt_req)  state_d = StHalt;
          else if (go)   state_d = StFetch;
        end
      end
      StFetch: begin
        if (fetch_ack)        state_d = StExec;
        else if (timeout_hit) state_d = StFault;
      end
      StExec: begin
        if (exec_done) state_d = StAdvance;
      end
      StAdvance: begin
        if (halt_pend_q || halt_req) state_d = StHalt;
        else if (run)                state_d = StFetch;
        else                         state_d = StIdle;
      end
      StHalt, StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = '0;
    halt_pend_d = halt_pend_q;
    mirror_d    = mirror_q;
    instr_d     = instr_q;
    ip_adj_d    = ip_adj_q;
    unique case (state_q)
      StFetch: begin
        if (fetch_ack) instr_d = fetch_data;
        else           cnt_d   = cnt_q + CntW'(1);
        if (halt_req)  halt_pend_d = 1'b1;
      end
      StExec: begin
        if (exec_done) ip_adj_d = branch_taken ? branch_offset : SeqStep;
        if (halt_req)  halt_pend_d = 1'b1;
      end
      StAdvance: begin
        mirror_d    = mirror_q + ip_adj_q;
        halt_pend_d = 1'b0;
      end
      default: ;
    endcase
    fetch_req_d   = (state_d == StFetch);
    instr_valid_d = (state_d == StExec) && (state_q != StExec);
    ip_update_d   = (state_d == StAdvance);
    ip_reset_d    = !started_q;
    halted_d      = (state_d == StHalt);
    fault_d       = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q     <= 1'b0;
      cnt_q         <= '0;
      halt_pend_q   <= 1'b0;
      mirror_q      <= '0;
      instr_q       <= '0;
      ip_adj_q      <= '0;
      fetch_req_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      ip_update_q   <= 1'b0;
      ip_reset_q    <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      started_q     <= 1'b1;
      cnt_q         <= cnt_d;
      halt_pend_q   <= halt_pend_d;
      mirror_q      <= mirror_d;
      instr_q       <= instr_d;
      ip_adj_q      <= ip_adj_d;
      fetch_req_q   <= fetch_req_d;
      instr_valid_q <= instr_valid_d;
      ip_update_q   <= ip_update_d;
      ip_reset_q    <= ip_reset_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_addr  = mirror_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign ip_adj      = ip_adj_q;
  assign ip_update   = ip_update_q;
  assign ip_reset    = ip_reset_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed corner sequences, a branch/wrap vector table and a
// randomized run checked against an IP scoreboard.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [15:0] fetch_data = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic [15:0] ip_adj;
  logic        ip_update;
  logic        ip_reset;
  logic        halted;
  logic        fault;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .halt_req     (halt_req),
`ifdef SINGLE_STEP_EN
    .step         (step),
`endif
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .ip_adj       (ip_adj),
    .ip_update    (ip_update),
    .ip_reset     (ip_reset),
    .halted       (halted),
    .fault        (fault),
    .state        (state)
  );

  typedef struct {
    logic        taken;
    logic [15:0] off;
    logic [15:0] exp_adj;
    logic [15:0] exp_next;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic r);
    reset_n = 1'b0; run = r; halt_req = 1'b0; fetch_ack = 1'b0; fetch_data = '0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_offset = '0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_fetch_req", 32'(fetch_req), 0);
    check("rst_ip_reset", 32'(ip_reset), 0);
    reset_n = 1'b1;
    tick();
    check("rel_ip_reset", 32'(ip_reset), 1);
    check("rel_no_fetch", 32'(fetch_req), 0);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fetch_req && n < 30) begin
      tick();
      n++;
    end
    check("wait_fetch", 32'(fetch_req), 1);
  endtask

  task automatic exec_instr(input logic tk, input logic [15:0] off, input logic [15:0] data);
    fetch_ack = 1'b1; fetch_data = data;
    tick();
    fetch_ack = 1'b0;
    check("exec_valid", 32'(instr_valid), 1);
    check("exec_instr", 32'(instr), 32'(data));
    exec_done = 1'b1; branch_taken = tk; branch_offset = off;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0; branch_offset = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    logic [15:0] exp_ip;
    logic [15:0] exp_adj;
    logic        p_ack, p_done, p_tk;
    logic [15:0] p_data, p_off;
    int          fw;
    int          n;

    tbl[0] = '{1'b0, 16'h0000, 16'h0001, 16'h0001};
    tbl[1] = '{1'b1, 16'h0004, 16'h0004, 16'h0005};
    tbl[2] = '{1'b1, 16'hFFFE, 16'hFFFE, 16'h0003};
    tbl[3] = '{1'b1, 16'hFFFC, 16'hFFFC, 16'hFFFF};
    tbl[4] = '{1'b0, 16'hBEEF, 16'h0001, 16'h0000};
    tbl[5] = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 16'h1234, 16'h0001, 16'h0001};

    // Back-to-back 3-cycle instructions
    do_reset(1'b1);
    fetch_ack = 1'b1; exec_done = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_fetch_req", 32'(fetch_req), 1);
      check("seq_addr", 32'(fetch_addr), 32'(k));
      fetch_data = 16'hA000 + 16'(k);
      tick();
      check("seq_valid", 32'(instr_valid), 1);
      check("seq_instr", 32'(instr), 32'h0000A000 + 32'(k));
      tick();
      check("seq_update", 32'(ip_update), 1);
      check("seq_adj", 32'(ip_adj), 1);
      check("seq_no_ipreset", 32'(ip_reset), 0);
      tick();
    end
    fetch_ack = 1'b0; exec_done = 1'b0;

    // Branch / wrap vector table
    do_reset(1'b1);
    exp_ip = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      wait_fetch();
      check("tbl_addr", 32'(fetch_addr), 32'(exp_ip));
      exec_instr(tbl[i].taken, tbl[i].off, 16'h5000 + 16'(i));
      check("tbl_update", 32'(ip_update), 1);
      check("tbl_adj", 32'(ip_adj), 32'(tbl[i].exp_adj));
      exp_ip = tbl[i].exp_next;
    end
    wait_fetch();
    check("tbl_final_addr", 32'(fetch_addr), 32'(exp_ip));

    // Halt request during EXEC at IP=2
    do_reset(1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_fetch();
      exec_instr(1'b0, 16'h0000, 16'h1111);
    end
    wait_fetch();
    check("halt_addr", 32'(fetch_addr), 2);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check("halt_exec_valid", 32'(instr_valid), 1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("halt_update", 32'(ip_update), 1);
    tick();
    check("halt_halted", 32'(halted), 1);
    check("halt_state", 32'(state), 4);
    check("halt_addr_after", 32'(fetch_addr), 3);
    check("halt_no_fetch", 32'(fetch_req), 0);
    for (int i = 0; i < 8; i++) begin
      run = ~run; fetch_ack = 1'(i); exec_done = 1'b1;
      tick();
      check("halt_sticky", 32'({halted, fetch_req, ip_update}), 32'b100);
    end
    fetch_ack = 1'b0; exec_done = 1'b0;

    // Fetch timeout
    do_reset(1'b1);
    tick();
    n = 0;
    while (fetch_req && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 15);
    check("to_fault", 32'(fault), 1);
    check("to_fetch_req", 32'(fetch_req), 0);
    check("to_state", 32'(state), 5);
    fetch_ack = 1'b1;
    repeat (3) tick();
    fetch_ack = 1'b0;
    check("to_sticky", 32'({fault, fetch_req}), 32'b10);

    // Ack on exactly the 15th fetch cycle wins
    do_reset(1'b1);
    tick();
    repeat (14) tick();
    check("ack15_still_fetch", 32'(fetch_req), 1);
    fetch_ack = 1'b1; fetch_data = 16'h0F0F;
    tick();
    fetch_ack = 1'b0;
    check("ack15_valid", 32'(instr_valid), 1);
    check("ack15_state", 32'(state), 2);
    check("ack15_no_fault", 32'(fault), 0);

    // Async reset in the middle of EXEC
    do_reset(1'b1);
    wait_fetch();
    exec_instr(1'b1, 16'h0007, 16'h2222);
    wait_fetch();
    fetch_ack = 1'b1; fetch_data = 16'h3333;
    tick();
    fetch_ack = 1'b0;
    check("mid_valid", 32'(instr_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_outs", 32'({fetch_req, instr_valid, ip_update, ip_reset, halted, fault}), 0);
    check("async_addr", 32'(fetch_addr), 0);
    check("async_instr", 32'(instr), 0);
    check("async_adj", 32'(ip_adj), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("async_rel_ipreset", 32'(ip_reset), 1);
    tick();
    check("async_rel_once", 32'(ip_reset), 0);
    check("async_rel_fetch", 32'(fetch_req), 1);

`ifdef SINGLE_STEP_EN
    // Single-step with run low
    do_reset(1'b0);
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      check("step_idle", 32'(state), 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_fetch", 32'(fetch_req), 1);
      exec_instr(1'b0, 16'h0000, 16'h7000);
      if (ip_update) n++;
      tick();
      check("step_back_idle", 32'({state, fetch_req}), 0);
      tick();
    end
    check("step_updates", 32'(n), 3);
    check("step_addr", 32'(fetch_addr), 3);
`endif

    // Randomized run against the IP scoreboard
    do_reset(1'b1);
    exp_ip = '0;
    fw = 0;
    p_ack = 1'b0; p_done = 1'b0; p_tk = 1'b0; p_data = '0; p_off = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      check("rnd_no_overlap", 32'(ip_update & ip_reset), 0);
      check("rnd_no_stop", 32'({fault, halted}), 0);
      if (fetch_req) check("rnd_addr", 32'(fetch_addr), 32'(exp_ip));
      if (instr_valid) check("rnd_instr", 32'({p_ack, instr}), 32'({1'b1, p_data}));
      if (ip_update) begin
        exp_adj = p_tk ? p_off : 16'h0001;
        check("rnd_done_seen", 32'(p_done), 1);
        check("rnd_adj", 32'(ip_adj), 32'(exp_adj));
        exp_ip = exp_ip + exp_adj;
      end
      fw = fetch_req ? fw + 1 : 0;
      run           = ($urandom_range(7) != 0);
      fetch_ack     = fetch_req && (($urandom_range(2) == 0) || fw >= 8);
      fetch_data    = 16'($urandom);
      exec_done     = ($urandom_range(2) == 0);
      branch_taken  = 1'($urandom);
      branch_offset = 16'($urandom);
      p_ack = fetch_ack; p_data = fetch_data; p_done = exec_done;
      p_tk = branch_taken; p_off = branch_offset;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
